iq_avg_status_gen: RTL and testbench

IQ_AVG_STATUS_GEN -- requirements
Module: iq_avg_status_gen

---
 rtl/iq_avg_status_gen.sv | 247 ++++++++++++++++++++++++
 tb/tb_iq_avg_status_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/iq_avg_status_gen.sv
// -----------------------------------------------------------------------------
// iq_avg_status_gen
//
// Averages complex (I/Q) samples over a window of N = 2^LOG_N accepted samples
// and publishes a 32-bit status word for a processor-visible register.
//
// A start pulse arms one window. Samples qualified by in_valid are summed into
// DW+LOG_N-bit accumulators, which are wide enough that N full-scale samples
// cannot overflow. After the N-th sample the block spends one cycle in DUMP,
// where avg_valid is high and avg_i/avg_q hold floor(sum / N). A stop pulse
// abandons the window without producing a result.
//
// Build option:
//   IQ_AVG_CONTINUOUS_EN  when defined, DUMP re-arms immediately (back-to-back
//                         windows) until stop or reset. When undefined, DUMP
//                         returns to IDLE unless start is high during DUMP.
//
// Parameters:
//   DW     signed width of each I and Q sample
//   LOG_N  log2 of the window length, legal range 1..12
//
// Ports:
//   user_clk    single clock for all logic
//   user_rst    asynchronous active-high reset
//   start       one-cycle pulse, arms a window
//   stop        one-cycle pulse, aborts the current window
//   clr_sticky  clears sticky status bits start_ovr and drop
//   in_valid    qualifies in_i / in_q
//   in_i, in_q  signed input samples
//   avg_valid   one-cycle result strobe
//   avg_i/avg_q signed averages, held until the next avg_valid
//   status      registered status word:
//                 [31] busy, [30] start_ovr, [29] drop, [28:27] state,
//                 [26:15] sample counter, [14:0] completed window count
// -----------------------------------------------------------------------------
module iq_avg_status_gen #(
  parameter int DW    = 16,
  parameter int LOG_N = 8
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clr_sticky,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  output logic                 avg_valid,
  output logic signed [DW-1:0] avg_i,
  output logic signed [DW-1:0] avg_q,
  output logic [31:0]          status
);

  localparam int AW = DW + LOG_N;

  // The sample counter is LOG_N bits wide and wraps to zero on the N-th
  // sample, so N-1 (all ones) marks the last sample of a window.
  localparam logic [LOG_N-1:0] CNT_LAST = '1;
  localparam logic [LOG_N-1:0] CNT_ONE  = LOG_N'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_DUMP = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic signed [AW-1:0] acc_i_q, acc_i_d;
  logic signed [AW-1:0] acc_q_q, acc_q_d;
  logic signed [AW-1:0] ext_i, ext_q;
  logic [LOG_N-1:0]     cnt_q, cnt_d;
  logic [14:0]          done_q, done_d;
  logic                 start_ovr_q, start_ovr_d;
  logic                 drop_q, drop_d;
  logic                 avg_valid_q, avg_valid_d;
  logic signed [DW-1:0] avg_i_q, avg_i_d;
  logic signed [DW-1:0] avg_q_q, avg_q_d;
  logic [31:0]          status_q, status_d;

  // Control strobes decoded from the FSM.
  logic acc_clr;
  logic acc_en;
  logic cnt_clr;
  logic win_done;
  logic dump;
  logic ovr_set;
  logic drop_set;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACC;
      end
      ST_ACC: begin
        // stop has priority over the N-th sample: the window is abandoned.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (in_valid && (cnt_q == CNT_LAST)) begin
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
`ifdef IQ_AVG_CONTINUOUS_EN
        state_d = stop ? ST_IDLE : ST_ACC;
`else
        state_d = start ? ST_ACC : ST_IDLE;
`endif
      end
      // Encoding 2'b11 is never entered; fall back to IDLE if it ever appears.
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output (control) logic
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    cnt_clr  = 1'b0;
    win_done = 1'b0;
    dump     = 1'b0;
    ovr_set  = 1'b0;
    drop_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_clr = start;
        cnt_clr = start;
      end
      ST_ACC: begin
        acc_en   = in_valid && !stop;
        win_done = in_valid && !stop && (cnt_q == CNT_LAST);
        // A stopped window leaves a clean counter so status reads zero in IDLE.
        cnt_clr  = stop;
        ovr_set  = start;
      end
      ST_DUMP: begin
        dump     = 1'b1;
        drop_set = in_valid;
        // Re-arming from DUMP starts the new window from a zero sum.
        acc_clr  = (state_d == ST_ACC);
        cnt_clr  = (state_d == ST_ACC);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  assign ext_i = {{LOG_N{in_i[DW-1]}}, in_i};
  assign ext_q = {{LOG_N{in_q[DW-1]}}, in_q};

  always_comb begin
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    if (acc_clr) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (acc_en) begin
      acc_i_d = acc_i_q + ext_i;
      acc_q_d = acc_q_q + ext_q;
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (acc_en) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // The result registers load on the edge that enters DUMP, so avg_valid and
    // the averages are presented together during the DUMP cycle. Dropping the
    // low LOG_N bits of a two's-complement sum is an arithmetic shift right,
    // i.e. floor division by N.
    avg_valid_d = win_done;
    avg_i_d     = win_done ? acc_i_d[AW-1:LOG_N] : avg_i_q;
    avg_q_d     = win_done ? acc_q_d[AW-1:LOG_N] : avg_q_q;

    done_d = dump ? done_q + 15'd1 : done_q;

    // Sticky bits: a set event in the same cycle beats clr_sticky.
    start_ovr_d = clr_sticky ? 1'b0 : start_ovr_q;
    if (ovr_set) start_ovr_d = 1'b1;
    drop_d = clr_sticky ? 1'b0 : drop_q;
    if (drop_set) drop_d = 1'b1;

    // Built from current register values, so status trails them by one cycle.
    status_d = {(state_q != ST_IDLE), start_ovr_q, drop_q, state_q,
                12'(cnt_q), done_q};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      start_ovr_q <= 1'b0;
      drop_q      <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_i_q     <= '0;
      avg_q_q     <= '0;
      status_q    <= '0;
    end else begin
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      start_ovr_q <= start_ovr_d;
      drop_q      <= drop_d;
      avg_valid_q <= avg_valid_d;
      avg_i_q     <= avg_i_d;
      avg_q_q     <= avg_q_d;
      status_q    <= status_d;
    end
  end

  assign avg_valid = avg_valid_q;
  assign avg_i     = avg_i_q;
  assign avg_q     = avg_q_q;
  assign status    = status_q;

endmodule

// File: tb/tb_iq_avg_status_gen.sv
// -----------------------------------------------------------------------------
// tb_iq_avg_status_gen
//
// Directed bench for iq_avg_status_gen with DW=16, LOG_N=2 (N=4). Inputs are
// driven 1 time unit after the rising edge and outputs are read at that point,
// so every check sees the registers updated by the edge just taken.
// Define IQ_AVG_CONTINUOUS_EN for both RTL and bench to run the back-to-back
// window scenario instead of the single-window scenarios.
// -----------------------------------------------------------------------------
module tb_iq_avg_status_gen;

  localparam int DW    = 16;
  localparam int LOG_N = 2;

  logic                 user_clk;
  logic                 user_rst;
  logic                 start;
  logic                 stop;
  logic                 clr_sticky;
  logic                 in_valid;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic                 avg_valid;
  logic signed [DW-1:0] avg_i;
  logic signed [DW-1:0] avg_q;
  logic [31:0]          status;

  int n_checks = 0;
  int n_pass   = 0;

  iq_avg_status_gen #(
    .DW    (DW),
    .LOG_N (LOG_N)
  ) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .start      (start),
    .stop       (stop),
    .clr_sticky (clr_sticky),
    .in_valid   (in_valid),
    .in_i       (in_i),
    .in_q       (in_q),
    .avg_valid  (avg_valid),
    .avg_i      (avg_i),
    .avg_q      (avg_q),
    .status     (status)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, take the edge, then return pulses to idle.
  task automatic cyc(input logic s, input logic sp, input logic c,
                     input logic v, input logic signed [DW-1:0] i,
                     input logic signed [DW-1:0] q);
    start      = s;
    stop       = sp;
    clr_sticky = c;
    in_valid   = v;
    in_i       = i;
    in_q       = q;
    @(posedge user_clk);
    #1;
    start      = 1'b0;
    stop       = 1'b0;
    clr_sticky = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic sample(input logic signed [DW-1:0] i,
                        input logic signed [DW-1:0] q);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, i, q);
  endtask

  initial begin
    user_rst   = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    clr_sticky = 1'b0;
    in_valid   = 1'b0;
    in_i       = '0;
    in_q       = '0;

    // ---------------- reset ----------------
    #2 user_rst = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;
    check("rst_avg_valid", 32'(avg_valid), 32'd0);
    check("rst_avg_i",     32'(avg_i),     32'd0);
    check("rst_avg_q",     32'(avg_q),     32'd0);
    check("rst_status",    status,         32'd0);
    user_rst = 1'b0;
    idle();

`ifdef IQ_AVG_CONTINUOUS_EN
    // ---------------- continuous windows, constant I=7 ----------------
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 14; k++) begin
      sample(16'sd7, 16'sd0);
      check("cont_avg_valid", 32'(avg_valid), 32'((k % 5) == 4));
      if ((k % 5) == 4) check("cont_avg_i", 32'(avg_i), 32'(7));
      check("cont_drop", 32'(status[29]), 32'(k >= 6));
    end
    // Third DUMP is in progress; stop returns to IDLE.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'sd7, 16'sd0);
    idle();
    check("cont_stop_busy",  32'(status[31]),    32'd0);
    check("cont_stop_state", 32'(status[28:27]), 32'd0);
    check("cont_done",       32'(status[14:0]),  32'd3);
    check("cont_no_strobe",  32'(avg_valid),     32'd0);
`else
    // ---------------- basic window: I 4,8,-4,12  Q -1,-1,-1,-2 ----------------
    sample(16'sd1000, 16'sd1000);                 // dropped in IDLE
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    sample(16'sd4, -16'sd1);
    sample(16'sd8, -16'sd1);
    sample(-16'sd4, -16'sd1);
    sample(16'sd12, -16'sd2);
    check("w1_avg_valid", 32'(avg_valid), 32'd1);
    check("w1_avg_i",     32'(avg_i),     32'(5));
    check("w1_avg_q",     32'(avg_q),     32'(-2));
    check("w1_status_acc", status,        32'h8801_8000);
    idle();
    check("w1_strobe_one", 32'(avg_valid), 32'd0);
    check("w1_avg_i_held", 32'(avg_i),     32'(5));
    check("w1_status_dump", status,        32'h9000_0000);
    idle();
    check("w1_status_idle", status,        32'h0000_0001);

    // ---------------- start inside ACC, drop in DUMP, clr_sticky ----------------
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    sample(16'sd1, 16'sd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'sd2, 16'sd0);  // start ignored, start_ovr set
    sample(16'sd3, 16'sd0);
    sample(16'sd6, 16'sd0);
    check("w2_avg_valid", 32'(avg_valid), 32'd1);
    check("w2_avg_i",     32'(avg_i),     32'(3));
    check("w2_status",    status,         32'hC801_8001);
    sample(16'sd99, 16'sd99);                     // arrives in DUMP
    check("w2_after_dump", status,        32'hD000_0001);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    check("w2_sticky_seen", status,       32'h6000_0002);
    idle();
    check("w2_sticky_clr",  status,       32'h0000_0002);

    // ---------------- set beats clr, stop on the N-th sample ----------------
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    sample(16'sd1, 16'sd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'sd1, 16'sd1);
    sample(16'sd1, 16'sd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'sd1, 16'sd1);
    check("w3_no_strobe", 32'(avg_valid), 32'd0);
    check("w3_avg_i_held", 32'(avg_i),    32'(3));
    idle();
    check("w3_status_idle", status,       32'h4000_0002);
    check("w3_no_late_strobe", 32'(avg_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    idle();

    // ---------------- reset mid-window ----------------
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    sample(16'sd100, 16'sd100);
    sample(16'sd100, 16'sd100);
    #3 user_rst = 1'b1;
    #1;
    check("mid_rst_avg_valid", 32'(avg_valid), 32'd0);
    check("mid_rst_avg_i",     32'(avg_i),     32'd0);
    check("mid_rst_status",    status,         32'd0);
    @(posedge user_clk);
    #1 user_rst = 1'b0;
    idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    sample(-16'sd8, 16'sd3);
    sample(-16'sd8, 16'sd3);
    sample(-16'sd8, 16'sd3);
    sample(-16'sd8, 16'sd2);
    check("w4_avg_valid", 32'(avg_valid), 32'd1);
    check("w4_avg_i",     32'(avg_i),     32'(-8));
    check("w4_avg_q",     32'(avg_q),     32'(2));

    // ---------------- start in DUMP re-arms with a cleared sum ----------------
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);          // DUMP of w4, start held
    check("w5_rearm_busy", 32'(avg_valid), 32'd0);
    sample(16'sd10, -16'sd10);
    sample(16'sd10, -16'sd10);
    sample(16'sd10, -16'sd10);
    sample(16'sd10, -16'sd10);
    check("w5_avg_valid", 32'(avg_valid), 32'd1);
    check("w5_avg_i",     32'(avg_i),     32'(10));
    check("w5_avg_q",     32'(avg_q),     32'(-10));
    idle();
    idle();
    check("w5_status_idle", status,       32'h0000_0002);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
